// File: rtl/connect_n_engine.sv
// connect_n_engine: Connect-N game core.
// Owns the board, per-column gravity heights, turn alternation and a
// sequential win scan that checks one of four line directions per cycle
// after each accepted move.
module connect_n_engine #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int CW      = $clog2(COLS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_game,
  input  logic                       first_player,
  input  logic                       move_valid,
  input  logic [CW-1:0]              move_col,
  output logic                       move_ready,
  output logic                       move_ack,
  output logic                       move_reject,
  output logic [2*ROWS*COLS-1:0]     grid,
  output logic [COLS-1:0]            valid_cols,
  output logic [1:0]                 current_player,
  output logic [$clog2(ROWS)-1:0]    last_row,
  output logic [CW-1:0]              last_col,
  output logic                       game_over,
  output logic [1:0]                 winner,
  output logic [ROWS*COLS-1:0]       win_mask
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int NK = 2 * WIN_LEN - 1;   // offsets -(WIN_LEN-1)..+(WIN_LEN-1)

  typedef enum logic [1:0] {ST_READY, ST_CHECK, ST_OVER} state_t;

  state_t          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      player_q, player_d;
  logic [1:0]      cell_q [N];
  logic [1:0]      cell_d [N];
  logic [HW-1:0]   height_q [COLS];
  logic [HW-1:0]   height_d [COLS];
  logic [RW-1:0]   last_row_q, last_row_d;
  logic [CW-1:0]   last_col_q, last_col_d;
  logic            ack_q, ack_d;
  logic            rej_q, rej_d;
  logic [1:0]      winner_q, winner_d;
  logic [N-1:0]    win_mask_q, win_mask_d;
  logic            win_found_q, win_found_d;

  // Line-scan signals for the direction currently being checked
  logic [NK-1:0]   line_match;
  logic [IW-1:0]   line_idx [NK];
  logic            dir_win;
  logic [N-1:0]    dir_mask;
  int              dr, dc, rr, cc;

  // Move decode signals
  logic [HW-1:0]   sel_height;
  logic            col_ok;
  logic            all_full;

  // Scan the line through the last cell in direction dir_q; report the first
  // WIN_LEN window (lowest start offset) that is entirely the mover's colour.
  always_comb begin
    dr = (dir_q == 2'd0) ? 0 : 1;
    case (dir_q)
      2'd0:    dc = 1;
      2'd1:    dc = 0;
      2'd2:    dc = 1;
      default: dc = -1;
    endcase
    rr         = 0;
    cc         = 0;
    line_match = '0;
    dir_win    = 1'b0;
    dir_mask   = '0;
    for (int j = 0; j < NK; j++) begin
      line_idx[j] = '0;
      rr = int'(last_row_q) + (j - (WIN_LEN - 1)) * dr;
      cc = int'(last_col_q) + (j - (WIN_LEN - 1)) * dc;
      if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
        line_idx[j]   = IW'(rr * COLS + cc);
        line_match[j] = (cell_q[line_idx[j]] == player_q);
      end
    end
    for (int s = 0; s < WIN_LEN; s++) begin
      if (!dir_win && (&line_match[s +: WIN_LEN])) begin
        dir_win = 1'b1;
        for (int t = 0; t < WIN_LEN; t++) begin
          dir_mask[line_idx[s + t]] = 1'b1;
        end
      end
    end
  end

  // Select the requested column's height; out-of-range columns leave col_ok low.
  always_comb begin
    sel_height = '0;
    col_ok     = 1'b0;
    all_full   = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (move_col == CW'(c)) begin
        sel_height = height_q[c];
        col_ok     = 1'b1;
      end
      if (height_q[c] != HW'(ROWS)) begin
        all_full = 1'b0;
      end
    end
  end

  // Game FSM next-state: accept/reject moves, walk directions, resolve; new_game overrides all.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    player_d    = player_q;
    cell_d      = cell_q;
    height_d    = height_q;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
    ack_d       = 1'b0;
    rej_d       = 1'b0;
    winner_d    = winner_q;
    win_mask_d  = win_mask_q;
    win_found_d = win_found_q;

    case (state_q)
      ST_READY: begin
        if (move_valid) begin
          if (!col_ok || sel_height == HW'(ROWS)) begin
            rej_d = 1'b1;
          end else begin
            for (int c = 0; c < COLS; c++) begin
              if (move_col == CW'(c)) begin
                cell_d[IW'(int'(sel_height) * COLS + c)] = player_q;
                height_d[c] = height_q[c] + HW'(1);
              end
            end
            last_row_d  = RW'(sel_height);
            last_col_d  = move_col;
            ack_d       = 1'b1;
            dir_d       = 2'd0;
            win_found_d = 1'b0;
            state_d     = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // Keep only the first winning line found (lowest direction).
        if (dir_win && !win_found_q) begin
          win_found_d = 1'b1;
          win_mask_d  = dir_mask;
        end
        if (dir_q == 2'd3) begin
          if (win_found_q || dir_win) begin
            state_d  = ST_OVER;
            winner_d = player_q;
          end else if (all_full) begin
            state_d  = ST_OVER;
            winner_d = 2'b00;
          end else begin
            player_d = ~player_q;
            state_d  = ST_READY;
          end
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      default: begin
      end
    endcase

    if (new_game) begin
      state_d     = ST_READY;
      dir_d       = 2'd0;
      player_d    = first_player ? 2'b10 : 2'b01;
      for (int i = 0; i < N; i++) begin
        cell_d[i] = 2'b00;
      end
      for (int c = 0; c < COLS; c++) begin
        height_d[c] = '0;
      end
      last_row_d  = '0;
      last_col_d  = '0;
      ack_d       = 1'b0;
      rej_d       = 1'b0;
      winner_d    = 2'b00;
      win_mask_d  = '0;
      win_found_d = 1'b0;
    end
  end

  // State register with asynchronous clear to an empty board, P1 to move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READY;
      dir_q       <= 2'd0;
      player_q    <= 2'b01;
      for (int i = 0; i < N; i++) begin
        cell_q[i] <= 2'b00;
      end
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= '0;
      end
      last_row_q  <= '0;
      last_col_q  <= '0;
      ack_q       <= 1'b0;
      rej_q       <= 1'b0;
      winner_q    <= 2'b00;
      win_mask_q  <= '0;
      win_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      player_q    <= player_d;
      cell_q      <= cell_d;
      height_q    <= height_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      ack_q       <= ack_d;
      rej_q       <= rej_d;
      winner_q    <= winner_d;
      win_mask_q  <= win_mask_d;
      win_found_q <= win_found_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grid
      assign grid[gi*2 +: 2] = cell_q[gi];
    end
    for (gi = 0; gi < COLS; gi++) begin : g_valid
      assign valid_cols[gi] = (height_q[gi] != HW'(ROWS));
    end
  endgenerate

  assign move_ready     = (state_q == ST_READY);
  assign move_ack       = ack_q;
  assign move_reject    = rej_q;
  assign current_player = (state_q == ST_OVER) ? 2'b00 : player_q;
  assign last_row       = last_row_q;
  assign last_col       = last_col_q;
  assign game_over      = (state_q == ST_OVER);
  assign winner         = winner_q;
  assign win_mask       = win_mask_q;

endmodule

// File: tb/tb_connect_n_engine.sv
// Directed bench for connect_n_engine: default 6x7x4 instance plus a 3x3x3
// instance for the draw case. Expected move outcomes are queued when a move
// is driven and popped when the DUT responds.
module tb_connect_n_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: default parameters
  logic        a_ng, a_fp, a_valid;
  logic [2:0]  a_col;
  logic        a_ready, a_ack, a_rej;
  logic [83:0] a_grid;
  logic [6:0]  a_vc;
  logic [1:0]  a_player;
  logic [2:0]  a_lrow;
  logic [2:0]  a_lcol;
  logic        a_over;
  logic [1:0]  a_win;
  logic [41:0] a_mask;

  // Instance B: 3x3, win length 3
  logic        b_ng, b_fp, b_valid;
  logic [1:0]  b_col;
  logic        b_ready, b_ack, b_rej;
  logic [17:0] b_grid;
  logic [2:0]  b_vc;
  logic [1:0]  b_player;
  logic [1:0]  b_lrow;
  logic [1:0]  b_lcol;
  logic        b_over;
  logic [1:0]  b_win;
  logic [8:0]  b_mask;

  connect_n_engine u_a (
    .clk(clk), .rst(rst), .new_game(a_ng), .first_player(a_fp),
    .move_valid(a_valid), .move_col(a_col), .move_ready(a_ready),
    .move_ack(a_ack), .move_reject(a_rej), .grid(a_grid), .valid_cols(a_vc),
    .current_player(a_player), .last_row(a_lrow), .last_col(a_lcol),
    .game_over(a_over), .winner(a_win), .win_mask(a_mask)
  );

  connect_n_engine #(.ROWS(3), .COLS(3), .WIN_LEN(3)) u_b (
    .clk(clk), .rst(rst), .new_game(b_ng), .first_player(b_fp),
    .move_valid(b_valid), .move_col(b_col), .move_ready(b_ready),
    .move_ack(b_ack), .move_reject(b_rej), .grid(b_grid), .valid_cols(b_vc),
    .current_player(b_player), .last_row(b_lrow), .last_col(b_lcol),
    .game_over(b_over), .winner(b_win), .win_mask(b_mask)
  );

  typedef struct {
    bit         legal;
    int         row;
    int         col;
    logic [1:0] player;
  } exp_t;

  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;

  // Bench-side board models
  int         h_a[7];
  logic [1:0] bd_a[42];
  logic [1:0] cur_a;
  int         h_b[3];
  logic [1:0] bd_b[9];
  logic [1:0] cur_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [83:0] model_grid_a();
    logic [83:0] g;
    g = '0;
    for (int i = 0; i < 42; i++) g[i*2 +: 2] = bd_a[i];
    return g;
  endfunction

  function automatic logic [17:0] model_grid_b();
    logic [17:0] g;
    g = '0;
    for (int i = 0; i < 9; i++) g[i*2 +: 2] = bd_b[i];
    return g;
  endfunction

  task automatic clear_a(input logic [1:0] p);
    for (int i = 0; i < 42; i++) bd_a[i] = 2'b00;
    for (int c = 0; c < 7; c++) h_a[c] = 0;
    cur_a = p;
  endtask

  // One move on A: drive, check ack/reject, then follow the check phase.
  task automatic move_a(input int col, input bit over, input logic [1:0] win);
    exp_t e;
    e.legal  = (col < 7) ? (h_a[col] < 6) : 1'b0;
    e.row    = e.legal ? h_a[col] : 0;
    e.col    = col;
    e.player = cur_a;
    @(negedge clk);
    a_valid = 1'b1;
    a_col   = 3'(col);
    sb.push_back(e);
    @(negedge clk);
    a_valid = 1'b0;
    e = sb.pop_front();
    $display("A move col=%0d legal=%0d player=%0d ack=%0b rej=%0b", e.col, e.legal, e.player, a_ack, a_rej);
    chk("a_ack", a_ack, e.legal);
    chk("a_reject", a_rej, !e.legal);
    if (e.legal) begin
      bd_a[e.row*7 + e.col] = e.player;
      h_a[e.col]++;
      chk("a_last_row", a_lrow, e.row);
      chk("a_last_col", a_lcol, e.col);
      chk("a_grid", a_grid, model_grid_a());
      chk("a_busy", a_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk("a_busy_e3", a_ready, 1'b0);
      @(negedge clk);
      if (over) begin
        chk("a_game_over", a_over, 1'b1);
        chk("a_winner", a_win, win);
        chk("a_ready_over", a_ready, 1'b0);
        chk("a_player_over", a_player, 2'b00);
      end else begin
        cur_a = ~cur_a;
        chk("a_player_next", a_player, cur_a);
        chk("a_ready_next", a_ready, 1'b1);
        chk("a_not_over", a_over, 1'b0);
      end
    end else begin
      chk("a_grid_kept", a_grid, model_grid_a());
      chk("a_player_kept", a_player, cur_a);
      chk("a_ready_kept", a_ready, 1'b1);
    end
  endtask

  task automatic move_b(input int col, input bit over);
    exp_t e;
    e.legal  = h_b[col] < 3;
    e.row    = h_b[col];
    e.col    = col;
    e.player = cur_b;
    @(negedge clk);
    b_valid = 1'b1;
    b_col   = 2'(col);
    sb.push_back(e);
    @(negedge clk);
    b_valid = 1'b0;
    e = sb.pop_front();
    $display("B move col=%0d player=%0d ack=%0b", e.col, e.player, b_ack);
    chk("b_ack", b_ack, e.legal);
    bd_b[e.row*3 + e.col] = e.player;
    h_b[e.col]++;
    chk("b_grid", b_grid, model_grid_b());
    repeat (4) @(negedge clk);
    if (over) begin
      chk("b_game_over", b_over, 1'b1);
      chk("b_winner_draw", b_win, 2'b00);
      chk("b_mask_draw", b_mask, 9'h000);
      chk("b_valid_cols_full", b_vc, 3'b000);
    end else begin
      cur_b = ~cur_b;
      chk("b_not_over", b_over, 1'b0);
      chk("b_player_next", b_player, cur_b);
    end
  endtask

  task automatic new_game_a(input logic fp);
    @(negedge clk);
    a_ng = 1'b1;
    a_fp = fp;
    @(negedge clk);
    a_ng = 1'b0;
    clear_a(fp ? 2'b10 : 2'b01);
    $display("A new_game first_player=%0b player=%0d", fp, a_player);
    chk("ng_grid", a_grid, 84'h0);
    chk("ng_valid_cols", a_vc, 7'h7F);
    chk("ng_player", a_player, cur_a);
    chk("ng_ready", a_ready, 1'b1);
    chk("ng_over", a_over, 1'b0);
    chk("ng_mask", a_mask, 42'h0);
  endtask

  initial begin
    int vseq[7];
    int mseq[10];
    int dseq[9];
    logic [41:0] m;

    vseq = '{0, 1, 0, 1, 0, 1, 0};
    mseq = '{1, 0, 3, 1, 3, 3, 2, 3, 2, 2};
    dseq = '{1, 0, 2, 1, 0, 2, 0, 1, 2};

    rst = 1'b1;
    a_ng = 0; a_fp = 0; a_valid = 0; a_col = 0;
    b_ng = 0; b_fp = 0; b_valid = 0; b_col = 0;
    clear_a(2'b01);
    for (int i = 0; i < 9; i++) bd_b[i] = 2'b00;
    for (int c = 0; c < 3; c++) h_b[c] = 0;
    cur_b = 2'b01;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    $display("reset state check");
    chk("rst_grid", a_grid, 84'h0);
    chk("rst_valid_cols", a_vc, 7'h7F);
    chk("rst_player", a_player, 2'b01);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_over", a_over, 1'b0);
    chk("rst_ack", a_ack, 1'b0);
    chk("rst_reject", a_rej, 1'b0);
    chk("rst_winner", a_win, 2'b00);

    // Vertical win for P1 in column 0
    for (int i = 0; i < 7; i++) move_a(vseq[i], i == 6, 2'b01);
    m = '0;
    m[0] = 1'b1; m[7] = 1'b1; m[14] = 1'b1; m[21] = 1'b1;
    chk("vert_mask", a_mask, m);
    @(negedge clk);
    a_valid = 1'b1;
    a_col = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      $display("A request after game over ack=%0b rej=%0b", a_ack, a_rej);
      chk("over_no_ack", a_ack, 1'b0);
      chk("over_no_reject", a_rej, 1'b0);
    end
    a_valid = 1'b0;

    // Middle-of-line diagonal win, P2 starts
    new_game_a(1'b1);
    for (int i = 0; i < 10; i++) move_a(mseq[i], i == 9, 2'b01);
    m = '0;
    m[0] = 1'b1; m[8] = 1'b1; m[16] = 1'b1; m[24] = 1'b1;
    chk("diag_mask", a_mask, m);

    // Full column and out-of-range rejects
    new_game_a(1'b0);
    for (int i = 0; i < 6; i++) move_a(2, 1'b0, 2'b00);
    move_a(2, 1'b0, 2'b00);
    chk("full_col_valid", a_vc[2], 1'b0);
    @(negedge clk);
    a_valid = 1'b1;
    a_col = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      $display("A held illegal request rej=%0b", a_rej);
      chk("held_reject", a_rej, 1'b1);
      chk("held_no_ack", a_ack, 1'b0);
    end
    a_valid = 1'b0;
    @(negedge clk);
    move_a(7, 1'b0, 2'b00);
    move_a(3, 1'b0, 2'b00);

    // new_game during CHECK, coincident with a move request
    @(negedge clk);
    a_valid = 1'b1;
    a_col = 3'd4;
    @(negedge clk);
    a_valid = 1'b0;
    chk("pre_restart_ack", a_ack, 1'b1);
    a_ng = 1'b1;
    a_fp = 1'b1;
    a_valid = 1'b1;
    a_col = 3'd5;
    @(negedge clk);
    a_ng = 1'b0;
    a_valid = 1'b0;
    clear_a(2'b10);
    $display("A restart mid-check player=%0d ready=%0b", a_player, a_ready);
    chk("restart_grid", a_grid, 84'h0);
    chk("restart_player", a_player, 2'b10);
    chk("restart_no_ack", a_ack, 1'b0);
    chk("restart_no_reject", a_rej, 1'b0);
    chk("restart_ready", a_ready, 1'b1);

    // Draw on the 3x3 instance
    for (int i = 0; i < 9; i++) move_b(dseq[i], i == 8);

    // Asynchronous reset in the middle of a check
    @(negedge clk);
    a_valid = 1'b1;
    a_col = 3'd0;
    @(negedge clk);
    a_valid = 1'b0;
    chk("pre_reset_ack", a_ack, 1'b1);
    rst = 1'b1;
    #1;
    $display("async reset mid-check grid=%0h player=%0d", a_grid, a_player);
    chk("async_rst_grid", a_grid, 84'h0);
    chk("async_rst_valid_cols", a_vc, 7'h7F);
    chk("async_rst_player", a_player, 2'b01);
    chk("async_rst_ready", a_ready, 1'b1);
    chk("async_rst_over", a_over, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
